// File: rtl/gen_cmd_pkg.sv
// rtl/gen_cmd_pkg.sv - shared types and constants for the UART command controller
package gen_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GET_CMD,
    GET_DATA,
    GET_CHK,
    EXEC,
    SEND_RESP,
    GAP,
    SEND_STAT,
    GAP2
  } state_t;

  localparam logic [7:0] CMD_WAVE          = 8'h01;
  localparam logic [7:0] CMD_FREQ          = 8'h02;
  localparam logic [7:0] CMD_STAT          = 8'h03;
  localparam logic [7:0] CMD_OUTEN         = 8'h04;
  localparam logic [7:0] ACK               = 8'h06;
  localparam logic [7:0] NAK               = 8'h15;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  function automatic logic [7:0] status_byte(input logic o, input logic [1:0] w,
                                             input logic [3:0] f);
    return {o, 1'b0, w, f};
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// rtl/uart_cmd_ctrl_if.sv - UART RX byte stream and TX enable/busy handshake
interface uart_cmd_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_en;
  logic [7:0] tx_data;

  modport slave (input rx_valid, rx_data, tx_busy, output tx_en, tx_data);
  modport master(output rx_valid, rx_data, tx_busy, input tx_en, tx_data);
endinterface

// File: rtl/cmd_timeout_timer.sv
// rtl/cmd_timeout_timer.sv - inter-byte silence counter with clear/enable and expire flag
module cmd_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Clear dominates so a byte arriving on the expiry cycle restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    count <= '0;
    else if (clr)                  count <= '0;
    else if (en && count != LAST)  count <= count + W'(1);
  end

  assign expire = en && (count == LAST);
endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - parses 4-byte UART command frames into generator config and replies ACK/NAK/status
module uart_cmd_ctrl
  import gen_cmd_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 250000,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_cmd_ctrl_if.slave     uart,
  output logic [1:0]         wave_sel,
  output logic [3:0]         freq_sel,
  output logic               out_en,
  output logic               cfg_update,
  output logic               frame_err
);

  state_t     state_q, state_d;
  logic [7:0] cmd_q, cmd_d, data_q, data_d, chk_q, chk_d, resp_q, resp_d;
  logic       stat_req_q, stat_req_d;
  logic       tx_en_q, tx_en_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [1:0] wave_d;
  logic [3:0] freq_d;
  logic       outen_d, cfg_d, err_d;
  logic       expire, in_frame, frame_ok, cmd_ok;

  assign in_frame = (state_q == GET_CMD) || (state_q == GET_DATA) || (state_q == GET_CHK);

  cmd_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (uart.rx_valid || state_q == IDLE),
    .en     (in_frame),
    .expire (expire)
  );

  assign frame_ok = (chk_q == (cmd_q ^ data_q));

  always_comb begin
    cmd_ok = 1'b0;
    case (cmd_q)
      CMD_WAVE:  cmd_ok = (data_q <= 8'd3);
      CMD_FREQ:  cmd_ok = (data_q <= 8'd15);
      CMD_STAT:  cmd_ok = 1'b1;
      CMD_OUTEN: cmd_ok = (data_q <= 8'd1);
      default:   cmd_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    chk_d      = chk_q;
    resp_d     = resp_q;
    stat_req_d = stat_req_q;
    tx_en_d    = 1'b0;
    tx_data_d  = tx_data_q;
    wave_d     = wave_sel;
    freq_d     = freq_sel;
    outen_d    = out_en;
    cfg_d      = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: if (uart.rx_valid && uart.rx_data == SYNC_BYTE) state_d = GET_CMD;
      GET_CMD: begin
        if (uart.rx_valid) begin
          cmd_d   = uart.rx_data;
          state_d = GET_DATA;
        end else if (expire) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      GET_DATA: begin
        if (uart.rx_valid) begin
          data_d  = uart.rx_data;
          state_d = GET_CHK;
        end else if (expire) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      GET_CHK: begin
        if (uart.rx_valid) begin
          chk_d   = uart.rx_data;
          state_d = EXEC;
        end else if (expire) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      EXEC: begin
        stat_req_d = 1'b0;
        state_d    = SEND_RESP;
        if (frame_ok && cmd_ok) begin
          resp_d = ACK;
          case (cmd_q)
            CMD_WAVE:  begin wave_d  = data_q[1:0]; cfg_d = 1'b1; end
            CMD_FREQ:  begin freq_d  = data_q[3:0]; cfg_d = 1'b1; end
            CMD_OUTEN: begin outen_d = data_q[0];   cfg_d = 1'b1; end
            default:   stat_req_d = 1'b1;
          endcase
        end else begin
          resp_d = NAK;
          err_d  = 1'b1;
        end
      end
      SEND_RESP: begin
        if (!uart.tx_busy) begin
          tx_en_d   = 1'b1;
          tx_data_d = resp_q;
          state_d   = GAP;
        end
      end
      // One idle cycle lets the transmitter raise busy before we look at it again.
      GAP: state_d = stat_req_q ? SEND_STAT : IDLE;
      SEND_STAT: begin
        if (!uart.tx_busy) begin
          tx_en_d   = 1'b1;
          tx_data_d = status_byte(out_en, wave_sel, freq_sel);
          state_d   = GAP2;
        end
      end
      GAP2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= 8'h00;
      data_q     <= 8'h00;
      chk_q      <= 8'h00;
      resp_q     <= 8'h00;
      stat_req_q <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      wave_sel   <= 2'd0;
      freq_sel   <= 4'd0;
      out_en     <= 1'b1;
      cfg_update <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      chk_q      <= chk_d;
      resp_q     <= resp_d;
      stat_req_q <= stat_req_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      wave_sel   <= wave_d;
      freq_sel   <= freq_d;
      out_en     <= outen_d;
      cfg_update <= cfg_d;
      frame_err  <= err_d;
    end
  end

  assign uart.tx_en   = tx_en_q;
  assign uart.tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - scoreboard bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] wave_sel;
  logic [3:0] freq_sel;
  logic       out_en, cfg_update, frame_err;

  uart_cmd_ctrl_if uif();

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(100), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart       (uif.slave),
    .wave_sel   (wave_sel),
    .freq_sel   (freq_sel),
    .out_en     (out_en),
    .cfg_update (cfg_update),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [7:0] exp_tx[$];
  logic [6:0] exp_cfg[$];
  bit         exp_err[$];
  logic [1:0] m_wave  = 2'd0;
  logic [3:0] m_freq  = 4'd0;
  logic       m_outen = 1'b1;

  int  busy_len = 3;
  int  busy_cnt = 0;
  bit  force_busy = 1'b0;
  bit  tx_en_seen = 1'b0;
  bit  prev_tx_en = 1'b0;
  int  tx_cyc_prev = 0, tx_cyc_last = 0, err_cyc = 0, last_byte_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises just after the edge that captured tx_en.
  always @(negedge clk) tx_en_seen = uif.tx_en;
  initial uif.tx_busy = 1'b0;
  always @(posedge clk) begin
    #1;
    if (tx_en_seen) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    uif.tx_busy = force_busy || (busy_cnt > 0);
  end

  // Monitor: pops expected responses whenever the DUT presents a pulse.
  always @(negedge clk) begin
    if (uif.tx_en) begin
      chk("tx_en_back_to_back", int'(prev_tx_en), 0);
      chk("tx_en_while_busy", int'(uif.tx_busy), 0);
      if (exp_tx.size() == 0) begin
        total++;
        $display("FAIL tx_en_unexpected: got tx_data 0x%0h expected no tx_en", uif.tx_data);
      end else chk("tx_data", int'(uif.tx_data), int'(exp_tx.pop_front()));
      tx_cyc_prev = tx_cyc_last;
      tx_cyc_last = cyc;
    end
    prev_tx_en = uif.tx_en;
    if (cfg_update) begin
      if (exp_cfg.size() == 0) begin
        total++;
        $display("FAIL cfg_update_unexpected: got cfg 0x%0h expected no pulse",
                 {wave_sel, freq_sel, out_en});
      end else chk("cfg_values", int'({wave_sel, freq_sel, out_en}), int'(exp_cfg.pop_front()));
    end
    if (frame_err) begin
      err_cyc = cyc;
      if (exp_err.size() == 0) begin
        total++;
        $display("FAIL frame_err_unexpected: got pulse expected none");
      end else begin
        void'(exp_err.pop_front());
        chk("frame_err_pulse", int'(frame_err), 1);
      end
    end
  end

  task automatic push_cfg(input logic [1:0] w, input logic [3:0] f, input logic o);
    m_wave = w; m_freq = f; m_outen = o;
    exp_cfg.push_back({w, f, o});
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uif.rx_valid = 1'b1;
    uif.rx_data  = b;
    @(negedge clk);
    uif.rx_valid = 1'b0;
    last_byte_cyc = cyc;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
    send_byte(8'hA5); send_byte(c); send_byte(d); send_byte(k);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_tx.size() + exp_cfg.size() + exp_err.size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk({tag, "_pending"}, exp_tx.size() + exp_cfg.size() + exp_err.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wave_sel"},   int'(wave_sel),    0);
    chk({tag, "_freq_sel"},   int'(freq_sel),    0);
    chk({tag, "_out_en"},     int'(out_en),      1);
    chk({tag, "_tx_en"},      int'(uif.tx_en),   0);
    chk({tag, "_tx_data"},    int'(uif.tx_data), 0);
    chk({tag, "_cfg_update"}, int'(cfg_update),  0);
    chk({tag, "_frame_err"},  int'(frame_err),   0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    uif.rx_valid = 1'b0;
    uif.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: set waveform to saw
    push_cfg(2'd2, 4'd0, 1'b1);
    exp_tx.push_back(8'h06);
    send_frame(8'h01, 8'h02, 8'h03);
    drain("t1");

    // 2: bad checksum
    exp_tx.push_back(8'h15);
    exp_err.push_back(1'b1);
    send_frame(8'h01, 8'h02, 8'h00);
    drain("t2");
    chk("t2_wave_kept", int'(wave_sel), int'(m_wave));

    // 3: frequency then status, status reply held off by a long busy
    push_cfg(2'd2, 4'd11, 1'b1);
    exp_tx.push_back(8'h06);
    send_frame(8'h02, 8'h0B, 8'h09);
    drain("t3a");
    busy_len = 50;
    exp_tx.push_back(8'h06);
    exp_tx.push_back(8'hAB);
    send_frame(8'h03, 8'h00, 8'h03);
    drain("t3b");
    chk("t3_stat_after_busy", int'((tx_cyc_last - tx_cyc_prev) >= 50), 1);
    busy_len = 3;

    // 4: mid-frame silence aborts, then output enable off
    exp_err.push_back(1'b1);
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (150) @(negedge clk);
    chk("t4_timeout_pending", exp_err.size(), 0);
    chk_range("t4_timeout_cycle", err_cyc - last_byte_cyc, 99, 101);
    push_cfg(2'd2, 4'd11, 1'b0);
    exp_tx.push_back(8'h06);
    send_frame(8'h04, 8'h00, 8'h04);
    drain("t4");

    // 5: junk dropped, unknown command NAKed, bytes during SEND_RESP ignored
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    exp_tx.push_back(8'h15);
    exp_err.push_back(1'b1);
    send_frame(8'h05, 8'h00, 8'h05);
    send_frame(8'h01, 8'h03, 8'h02);
    force_busy = 1'b0;
    drain("t5");
    chk("t5_wave_kept", int'(wave_sel), int'(m_wave));
    chk("t5_out_en_kept", int'(out_en), int'(m_outen));

    // 6: reset mid-frame, then a clean frequency write
    send_byte(8'hA5);
    send_byte(8'h02);
    rst_n = 1'b0;
    m_wave = 2'd0; m_freq = 4'd0; m_outen = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("t6_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push_cfg(2'd0, 4'd3, 1'b1);
    exp_tx.push_back(8'h06);
    send_frame(8'h02, 8'h03, 8'h01);
    drain("t6");
    chk("t6_freq_sel", int'(freq_sel), 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
